reg_decoder_bank: RTL

REG_DECODER_BANK -- requirements
Module: reg_decoder_bank

---
 rtl/reg_decoder_bank.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/reg_decoder_bank.sv
// reg_decoder_bank
//   CPU-facing register bank split into NUM_SLV channels of REGS_PER_SLV
//   registers each. A transfer is captured in IDLE, walks SETUP -> ACCESS
//   (WAIT_CYC cycles, skipped when 0) -> RESP, and completes with a single
//   cpu_ready strobe in RESP.
//
// Ports
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   cpu_sel    in   transfer request, sampled in IDLE only
//   cpu_wr     in   1 = write, 0 = read
//   cpu_addr   in   [ADDR_W-1:0] byte address {channel, offset}
//   cpu_wdata  in   [DATA_W-1:0] write data
//   lock       in   [NUM_SLV-1:0] per-channel write protect
//   cpu_rdata  out  [DATA_W-1:0] read data, non-zero only in RESP of a good read
//   cpu_ready  out  one-cycle transfer-complete strobe
//   cpu_err    out  unmapped access or write to a locked channel (RESP only)
//   slv_act    out  [NUM_SLV-1:0] one-hot active channel in SETUP/ACCESS
//
// state  | meaning
// IDLE   | waiting for cpu_sel, captures wr/addr/wdata
// SETUP  | address decoded, slv_act driven, wait counter cleared
// ACCESS | WAIT_CYC wait cycles, lock already sampled
// RESP   | cpu_ready strobe, read data / error presented

module reg_decoder_bank #(
    parameter int              ADDR_W       = 8,
    parameter int              DATA_W       = 8,
    parameter int              NUM_SLV      = 4,
    parameter int              REGS_PER_SLV = 8,
    parameter int              WAIT_CYC     = 1,
    parameter logic [DATA_W-1:0] RESET_VAL  = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cpu_sel,
    input  logic                cpu_wr,
    input  logic [ADDR_W-1:0]   cpu_addr,
    input  logic [DATA_W-1:0]   cpu_wdata,
    input  logic [NUM_SLV-1:0]  lock,
    output logic [DATA_W-1:0]   cpu_rdata,
    output logic                cpu_ready,
    output logic                cpu_err,
    output logic [NUM_SLV-1:0]  slv_act
);

    localparam int OFF_W = $clog2(REGS_PER_SLV);
    localparam int IDX_W = ADDR_W - OFF_W;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic              lock_hit_q, lock_hit_d;
    logic [DATA_W-1:0] regs_q [NUM_SLV][REGS_PER_SLV];
    logic [DATA_W-1:0] regs_d [NUM_SLV][REGS_PER_SLV];

    logic [IDX_W-1:0]   idx;
    logic [OFF_W-1:0]   off;
    logic [NUM_SLV-1:0] ch_oh;
    logic               mapped;
    logic               lock_now;
    logic [DATA_W-1:0]  rd_word;
    logic               enter_resp;
    logic               wr_blocked;

    assign idx = addr_q[ADDR_W-1:OFF_W];
    assign off = addr_q[OFF_W-1:0];

    // Decode from the captured address only; live CPU inputs never reach here.
    always_comb begin
        ch_oh   = '0;
        rd_word = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            ch_oh[i] = (idx == IDX_W'(i));
        end
        mapped   = |ch_oh;
        lock_now = |(lock & ch_oh);
        for (int i = 0; i < NUM_SLV; i++) begin
            for (int r = 0; r < REGS_PER_SLV; r++) begin
                if (ch_oh[i] && (off == OFF_W'(r))) begin
                    rd_word = regs_q[i][r];
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wait_cnt_d = wait_cnt_q;
        lock_hit_d = lock_hit_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_sel) begin
                    wr_d       = cpu_wr;
                    addr_d     = cpu_addr;
                    wdata_d    = cpu_wdata;
                    wait_cnt_d = '0;
                    state_d    = ST_SETUP;
                end
            end
            ST_SETUP: begin
                lock_hit_d = lock_now;
                wait_cnt_d = '0;
                if (WAIT_CYC == 0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt_q == 4'(WAIT_CYC - 1)) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // With WAIT_CYC=0 the lock sample and the write share one edge, so the
    // live lock bit is used there instead of the not-yet-loaded lock_hit_q.
    assign wr_blocked = (state_q == ST_SETUP) ? lock_now : lock_hit_q;

    always_comb begin
        regs_d = regs_q;
        if (enter_resp && wr_q && mapped && !wr_blocked) begin
            for (int i = 0; i < NUM_SLV; i++) begin
                for (int r = 0; r < REGS_PER_SLV; r++) begin
                    if (ch_oh[i] && (off == OFF_W'(r))) begin
                        regs_d[i][r] = wdata_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt_q <= '0;
            lock_hit_q <= 1'b0;
            for (int i = 0; i < NUM_SLV; i++) begin
                for (int r = 0; r < REGS_PER_SLV; r++) begin
                    regs_q[i][r] <= RESET_VAL;
                end
            end
        end else begin
            state_q    <= state_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wait_cnt_q <= wait_cnt_d;
            lock_hit_q <= lock_hit_d;
            regs_q     <= regs_d;
        end
    end

    assign cpu_ready = (state_q == ST_RESP);
    assign cpu_err   = cpu_ready && (!mapped || (wr_q && lock_hit_q));
    assign cpu_rdata = (cpu_ready && !wr_q && mapped) ? rd_word : '0;
    assign slv_act   = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? ch_oh : '0;

endmodule
